instruction_cache_assoc: RTL

Parametrised N-way set-associative instruction cache, the successor to the direct-mapped fetch cache. It sits between the fetch stage and instruction memory. It serves word-addressed reads with one-cycle hit latency and refills whole lines over a beat-by-beat memory handshake. Replacement is round-robin per set, and it supports a whole-cache flush.

---
 rtl/instruction_cache_assoc_pkg.sv | 28 ++
 rtl/instruction_cache_assoc_if.sv | 30 +++
 rtl/instruction_cache_assoc_way.sv | 50 +++++
 rtl/instruction_cache_assoc.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/instruction_cache_assoc_pkg.sv
// Shared definitions for the set-associative instruction cache: FSM states,
// default geometry and a constant log2 helper for address-field widths.
package instruction_cache_assoc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        RESPOND,
        FLUSH
    } cacheState_e;

    localparam int DEF_WAYS       = 2;
    localparam int DEF_SETS       = 16;
    localparam int DEF_WPL        = 4;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/instruction_cache_assoc_if.sv
// Fetch-side request/response and memory refill signals of the cache.
interface instruction_cache_assoc_if
    import instruction_cache_assoc_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WAYS       = DEF_WAYS
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_ready;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [WAYS-1:0]       busy;
    logic                  flush;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_data;

    modport slave (
        input  req_valid, req_addr, flush, mem_ready, mem_data,
        output req_ready, resp_valid, resp_data, busy, mem_req, mem_addr
    );

    modport master (
        output req_valid, req_addr, flush, mem_ready, mem_data,
        input  req_ready, resp_valid, resp_data, busy, mem_req, mem_addr
    );
endinterface

// File: rtl/instruction_cache_assoc_way.sv
// One way of the cache: valid flags in flops, tag and line storage in
// registered-read arrays, a whole-line write port and a per-set clear port.
module cache_way_array
    import instruction_cache_assoc_pkg::*;
#(
    parameter int SETS   = DEF_SETS,
    parameter int IDX_W  = clog2(SETS),
    parameter int TAG_W  = 26,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rdEn,
    input  logic [IDX_W-1:0]  rdIdx,
    output logic              rdValid,
    output logic [TAG_W-1:0]  rdTag,
    output logic [LINE_W-1:0] rdLine,
    input  logic              wrEn,
    input  logic [IDX_W-1:0]  wrIdx,
    input  logic [TAG_W-1:0]  wrTag,
    input  logic [LINE_W-1:0] wrLine,
    input  logic              clrEn,
    input  logic [IDX_W-1:0]  clrIdx
);
    logic [SETS-1:0]   validBits;
    logic [TAG_W-1:0]  tagMem  [SETS];
    logic [LINE_W-1:0] lineMem [SETS];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            tagMem[wrIdx]  <= wrTag;
            lineMem[wrIdx] <= wrLine;
        end
        if (rdEn) begin
            rdTag  <= tagMem[rdIdx];
            rdLine <= lineMem[rdIdx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validBits <= '0;
            rdValid   <= 1'b0;
        end else begin
            if (clrEn) validBits[clrIdx] <= 1'b0;
            if (wrEn)  validBits[wrIdx]  <= 1'b1;
            if (rdEn)  rdValid <= validBits[rdIdx];
        end
    end
endmodule

// File: rtl/instruction_cache_assoc.sv
// N-way set-associative instruction cache: FSM, tag compare, round-robin
// victim choice and the refill line buffer around WAYS way arrays.
module instruction_cache_assoc
    import instruction_cache_assoc_pkg::*;
#(
    parameter int WAYS           = DEF_WAYS,
    parameter int SETS           = DEF_SETS,
    parameter int WORDS_PER_LINE = DEF_WPL,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH
) (
    input logic clk,
    input logic reset,
    instruction_cache_assoc_if.slave bus
);
    localparam int OFF_W  = clog2(WORDS_PER_LINE);
    localparam int IDX_W  = clog2(SETS);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int PTR_W  = (WAYS > 1) ? clog2(WAYS) : 1;
    localparam int LINE_W = WORDS_PER_LINE * DATA_WIDTH;

    cacheState_e stateReg, stateNext;
    logic [ADDR_WIDTH-1:0] addrReg;
    logic [OFF_W-1:0]      beatReg;
    logic [IDX_W-1:0]      flushIdxReg;
    logic                  flushPendReg;
    logic                  startedReg;
    logic [WAYS-1:0]       victimReg;
    logic [PTR_W-1:0]      ptrReg [SETS];
    logic [DATA_WIDTH-1:0] lineBuf [WORDS_PER_LINE];

    logic [WAYS-1:0]       wayValid;
    logic [TAG_W-1:0]      wayTag  [WAYS];
    logic [LINE_W-1:0]     wayLine [WAYS];
    logic [WAYS-1:0]       hitVec, victimSel;
    logic [DATA_WIDTH-1:0] hitWord;
    logic [LINE_W-1:0]     wrLine;
    logic                  accept, found, lineDone, flushReq;

    wire [IDX_W-1:0] curIdx  = addrReg[OFF_W +: IDX_W];
    wire [TAG_W-1:0] curTag  = addrReg[ADDR_WIDTH-1 -: TAG_W];
    wire [OFF_W-1:0] curOff  = addrReg[OFF_W-1:0];
    wire             lastBeat = (beatReg == OFF_W'(WORDS_PER_LINE - 1));

    assign lineDone = (stateReg == REFILL) && bus.mem_ready && lastBeat;
    assign flushReq = bus.flush || flushPendReg;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : gWay
            cache_way_array #(
                .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)
            ) wayArray (
                .clk    (clk),
                .reset  (reset),
                .rdEn   (accept),
                .rdIdx  (bus.req_addr[OFF_W +: IDX_W]),
                .rdValid(wayValid[gi]),
                .rdTag  (wayTag[gi]),
                .rdLine (wayLine[gi]),
                .wrEn   (lineDone && victimReg[gi]),
                .wrIdx  (curIdx),
                .wrTag  (curTag),
                .wrLine (wrLine),
                .clrEn  (stateReg == FLUSH),
                .clrIdx (flushIdxReg)
            );
        end
    endgenerate

    always_comb begin
        hitVec    = '0;
        hitWord   = '0;
        victimSel = '0;
        found     = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            hitVec[w] = wayValid[w] && (wayTag[w] == curTag);
            if (hitVec[w]) hitWord = wayLine[w][int'(curOff) * DATA_WIDTH +: DATA_WIDTH];
            if (!wayValid[w] && !found) begin
                victimSel[w] = 1'b1;
                found        = 1'b1;
            end
        end
        if (!found) victimSel[ptrReg[curIdx]] = 1'b1;
    end

    // The final beat goes straight from the bus so the line lands on the same edge.
    always_comb begin
        wrLine = '0;
        for (int b = 0; b < WORDS_PER_LINE; b++) begin
            wrLine[b * DATA_WIDTH +: DATA_WIDTH] = (b == WORDS_PER_LINE - 1) ? bus.mem_data : lineBuf[b];
        end
    end

    always_comb begin
        stateNext      = stateReg;
        accept         = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        bus.busy       = '0;
        bus.mem_req    = 1'b0;
        bus.mem_addr   = '0;
        case (stateReg)
            IDLE: begin
                if (flushReq) begin
                    stateNext = FLUSH;
                end else begin
                    bus.req_ready = startedReg;
                    if (bus.req_valid && startedReg) begin
                        accept    = 1'b1;
                        stateNext = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                if (|hitVec) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_data  = hitWord;
                    bus.req_ready  = 1'b1;
                    accept         = bus.req_valid;
                    stateNext      = bus.req_valid ? LOOKUP : IDLE;
                end else begin
                    stateNext = REFILL;
                end
            end
            REFILL: begin
                bus.busy     = victimReg;
                bus.mem_req  = 1'b1;
                bus.mem_addr = {addrReg[ADDR_WIDTH-1:OFF_W], beatReg};
                if (lineDone) stateNext = RESPOND;
            end
            RESPOND: begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = lineBuf[curOff];
                stateNext      = IDLE;
            end
            FLUSH: begin
                if (flushIdxReg == IDX_W'(SETS - 1)) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if ((stateReg == REFILL) && bus.mem_ready) lineBuf[beatReg] <= bus.mem_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg     <= IDLE;
            addrReg      <= '0;
            beatReg      <= '0;
            flushIdxReg  <= '0;
            flushPendReg <= 1'b0;
            startedReg   <= 1'b0;
            victimReg    <= '0;
            for (int s = 0; s < SETS; s++) ptrReg[s] <= '0;
        end else begin
            stateReg   <= stateNext;
            startedReg <= 1'b1;
            // A flush seen outside IDLE waits; IDLE always hands it to FLUSH.
            flushPendReg <= (stateReg == IDLE) ? 1'b0 : (flushPendReg | bus.flush);
            if (accept) addrReg <= bus.req_addr;
            case (stateReg)
                LOOKUP: begin
                    if (!(|hitVec)) begin
                        victimReg <= victimSel;
                        beatReg   <= '0;
                    end
                end
                REFILL: begin
                    if (bus.mem_ready) beatReg <= beatReg + 1'b1;
                    if (lineDone && (&wayValid))
                        ptrReg[curIdx] <= PTR_W'((int'(ptrReg[curIdx]) + 1) % WAYS);
                end
                FLUSH: begin
                    flushIdxReg <= flushIdxReg + 1'b1;
                    if (flushIdxReg == IDX_W'(SETS - 1)) begin
                        for (int s = 0; s < SETS; s++) ptrReg[s] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
